// File: rtl/display_scheduler.sv
`default_nettype none
// display_scheduler: rotates four BCD readouts onto one scanned 4-digit seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits in modes 0, 2 and 3.
module display_scheduler #(
    parameter int DWELL_SEC = 2,
    parameter int SCAN_DIV  = 50000
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        one_Hz_clk,
    input  logic        next_btn,
    input  logic        hold,
    input  logic [19:0] m0_bcd,
    input  logic [19:0] m1_bcd,
    input  logic [19:0] m2_bcd,
    input  logic [19:0] m3_bcd,
    input  logic        si_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  mode,
    output logic        si
);

    localparam int              SCAN_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DWELL_LAST = 4'(DWELL_SEC - 1);

    typedef enum logic [1:0] {
        S_STEPS  = 2'd0,
        S_DIST   = 2'd1,
        S_OVER32 = 2'd2,
        S_HIGH   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_dwell;
    logic                r_si;
    logic [2:0]          r_hz_sync;
    logic [2:0]          r_btn_sync;
    logic                w_tick;
    logic                w_nxt;
    logic                w_adv;
    logic [3:0][4:0]     r_snap;
    logic                r_load_pend;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [1:0]          r_idx;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic [3:0]          w_blank;

    function automatic logic [19:0] f_pick(input state_t s, input logic [19:0] a,
                                           input logic [19:0] b, input logic [19:0] c,
                                           input logic [19:0] d);
        case (s)
            S_STEPS:  return a;
            S_DIST:   return b;
            S_OVER32: return c;
            default:  return d;
        endcase
    endfunction

    function automatic logic [6:0] f_dec(input logic [4:0] code);
        case (code)
            5'd0:    return 7'h40;
            5'd1:    return 7'h79;
            5'd2:    return 7'h24;
            5'd3:    return 7'h30;
            5'd4:    return 7'h19;
            5'd5:    return 7'h12;
            5'd6:    return 7'h02;
            5'd7:    return 7'h78;
            5'd8:    return 7'h00;
            5'd9:    return 7'h10;
            5'h1F:   return 7'h77;
            default: return 7'h7F;
        endcase
    endfunction

    // Two-flop synchronisers; the third bit is the previous value for edge detection.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_hz_sync  <= '0;
            r_btn_sync <= '0;
        end else begin
            r_hz_sync  <= {r_hz_sync[1:0], one_Hz_clk};
            r_btn_sync <= {r_btn_sync[1:0], next_btn};
        end
    end

    assign w_tick = r_hz_sync[1] & ~r_hz_sync[2];
    assign w_nxt  = r_btn_sync[1] & ~r_btn_sync[2];
    assign w_adv  = w_nxt | (w_tick & ~hold & (r_dwell == DWELL_LAST));

    always_comb begin
        case (r_state)
            S_STEPS:  w_state_nxt = S_DIST;
            S_DIST:   w_state_nxt = S_OVER32;
            S_OVER32: w_state_nxt = S_HIGH;
            default:  w_state_nxt = S_STEPS;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_STEPS;
            r_dwell <= '0;
            r_si    <= 1'b0;
        end else begin
            if (w_adv) begin
                r_state <= w_state_nxt;
                r_dwell <= '0;
            end else if (w_tick && !hold) begin
                r_dwell <= r_dwell + 4'd1;
            end
            r_si <= (w_adv ? (w_state_nxt == S_STEPS) : (r_state == S_STEPS)) ? si_in : 1'b0;
        end
    end

    // Snapshot only changes on mode changes, ticks, or the first edge after reset.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_snap      <= '0;
            r_load_pend <= 1'b1;
        end else if (w_adv) begin
            r_snap <= f_pick(w_state_nxt, m0_bcd, m1_bcd, m2_bcd, m3_bcd);
        end else if (w_tick) begin
            r_snap <= f_pick(r_state, m0_bcd, m1_bcd, m2_bcd, m3_bcd);
        end else if (r_load_pend) begin
            r_snap      <= m0_bcd;
            r_load_pend <= 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] w_zero;
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_zero[k] = (r_snap[k] == 5'd0);
        end
        w_blank    = 4'b0000;
        if (r_state != S_DIST) begin
            w_blank[3] = w_zero[3];
            w_blank[2] = w_zero[3] & w_zero[2];
            w_blank[1] = w_zero[3] & w_zero[2] & w_zero[1];
        end
    end
`else
    assign w_blank = 4'b0000;
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= 4'b1111;
            r_seg      <= 7'h7F;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank[r_idx] ? 7'h7F : f_dec(r_snap[r_idx]);
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign mode = r_state;
    assign si   = r_si;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// tb_display_scheduler: randomized scoreboard bench against an event-level reference model.
module tb_display_scheduler;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        one_Hz_clk = 1'b0;
    logic        next_btn = 1'b0;
    logic        hold = 1'b0;
    logic [19:0] m0_bcd = '0, m1_bcd = '0, m2_bcd = '0, m3_bcd = '0;
    logic        si_in = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  mode;
    logic        si;

    display_scheduler #(.DWELL_SEC(2), .SCAN_DIV(4)) dut (
        .sys_clk(sys_clk), .reset(reset), .one_Hz_clk(one_Hz_clk), .next_btn(next_btn),
        .hold(hold), .m0_bcd(m0_bcd), .m1_bcd(m1_bcd), .m2_bcd(m2_bcd), .m3_bcd(m3_bcd),
        .si_in(si_in), .an(an), .seg(seg), .mode(mode), .si(si)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0]  md;
        logic        s;
        logic [19:0] digs;
    } exp_t;

    exp_t exp_q[$];
    int   pushed_n = 0;
    int   popped_n = 0;
    int   checks = 0;
    int   failures = 0;
    int   m_mode = 0;
    int   m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [1:0] md, input logic [19:0] d, input int k);
        logic [4:0] c;
        c = d[5*k +: 5];
`ifdef LEADING_ZERO_BLANK_EN
        if (md != 2'd1 && k > 0 && (d >> (5*k)) == 20'd0) return 7'h7F;
`endif
        case (c)
            5'd0: return 7'h40;  5'd1: return 7'h79;  5'd2: return 7'h24;  5'd3: return 7'h30;
            5'd4: return 7'h19;  5'd5: return 7'h12;  5'd6: return 7'h02;  5'd7: return 7'h78;
            5'd8: return 7'h00;  5'd9: return 7'h10;  5'h1F: return 7'h77;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [19:0] rnd_digs();
        logic [19:0] d;
        int r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 15);
            if (r < 10)      d[5*k +: 5] = 5'(r);
            else if (r < 12) d[5*k +: 5] = 5'h1F;
            else if (r < 13) d[5*k +: 5] = 5'h0C;
            else             d[5*k +: 5] = 5'd0;
        end
        if ($urandom_range(0, 3) == 0) d[19:10] = '0;
        return d;
    endfunction

    function automatic logic [19:0] model_digs(input int md);
        case (md)
            0: return m0_bcd;
            1: return m1_bcd;
            2: return m2_bcd;
            default: return m3_bcd;
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        e.md   = 2'(m_mode);
        e.digs = model_digs(m_mode);
        e.s    = (m_mode == 0) ? si_in : 1'b0;
        exp_q.push_back(e);
        pushed_n++;
    endtask

    task automatic wait_mon();
        int n = 0;
        while (popped_n != pushed_n && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (popped_n != pushed_n) chk("monitor_timeout", 32'(popped_n), 32'(pushed_n));
    endtask

    // kind: 0 = one_Hz edge, 1 = next_btn press, 2 = both edges together
    task automatic do_event(input int kind);
        int old_mode = m_mode;
        if (kind != 0) begin
            m_mode = (m_mode + 1) % 4;
            m_cnt  = 0;
        end else if (!hold) begin
            m_cnt++;
            if (m_cnt == 2) begin
                m_mode = (m_mode + 1) % 4;
                m_cnt  = 0;
            end
        end
        if (kind != 1) one_Hz_clk = 1'b1;
        if (kind != 0) next_btn = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("mode_before_sync", 32'(mode), 32'(old_mode));
        @(negedge sys_clk);
        chk("mode_after_sync", 32'(mode), 32'(m_mode));
        repeat (3) @(negedge sys_clk);
        push_exp();
        m0_bcd = rnd_digs(); m1_bcd = rnd_digs(); m2_bcd = rnd_digs(); m3_bcd = rnd_digs();
        one_Hz_clk = 1'b0;
        next_btn   = 1'b0;
        repeat (4) @(negedge sys_clk);
        wait_mon();
    endtask

    // Monitor: pops one expectation and compares it against a full scan of the display.
    initial begin
        exp_t e;
        logic [3:0] seen;
        logic [3:0] prev_an;
        int run, bad, interior;
        bit first;
        forever begin
            @(negedge sys_clk);
            if (pushed_n != popped_n) begin
                e = exp_q.pop_front();
                chk("mode", 32'(mode), 32'(e.md));
                chk("si", 32'(si), 32'(e.s));
                seen = '0; prev_an = an; run = 1; bad = 0; interior = 0; first = 1'b1;
                for (int c = 0; c < 24; c++) begin
                    @(negedge sys_clk);
                    for (int k = 0; k < 4; k++) begin
                        if (an == ~(4'b0001 << k) && !seen[k]) begin
                            seen[k] = 1'b1;
                            chk($sformatf("seg_digit%0d", k), 32'(seg), 32'(exp_seg(e.md, e.digs, k)));
                        end
                    end
                    if (an == prev_an) run++;
                    else begin
                        if (!first) begin
                            interior++;
                            if (run != 4) bad = 1;
                        end
                        first = 1'b0; run = 1; prev_an = an;
                    end
                end
                chk("digits_seen", 32'(seen), 32'hF);
                chk("scan_dwell_ok", 32'((bad == 0) && (interior >= 4)), 32'd1);
                popped_n++;
            end
        end
    end

    initial begin
        int kind;
        // Power-on reset values
        repeat (2) @(negedge sys_clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_si", 32'(si), 32'd0);
        m0_bcd = rnd_digs(); m1_bcd = rnd_digs(); m2_bcd = rnd_digs(); m3_bcd = rnd_digs();
        reset = 1'b1;
        @(negedge sys_clk);
        chk("first_an", 32'(an), 32'hE);
        push_exp();
        wait_mon();

        // Auto-rotation: five ticks
        hold = 1'b0;
        for (int i = 0; i < 5; i++) do_event(0);
        // Hold ignores ticks, button still advances, then two ticks to the next advance
        hold = 1'b1;
        for (int i = 0; i < 4; i++) do_event(0);
        do_event(1);
        hold = 1'b0;
        do_event(0);
        do_event(0);
        // Coincident tick and button while dwell is one
        do_event(0);
        do_event(2);
        // Mode 1 pattern with underscore
        while (m_mode != 0) do_event(1);
        m1_bcd = {5'd0, 5'd3, 5'h1F, 5'd5};
        do_event(1);
        // Mode 0 with leading zeros and overflow flag
        do_event(1); do_event(1);
        m0_bcd = {5'd0, 5'd0, 5'd4, 5'd2};
        si_in  = 1'b1;
        do_event(1);
        do_event(1);

        // Randomized run
        for (int i = 0; i < 40; i++) begin
            hold  = ($urandom_range(0, 3) == 0);
            si_in = $urandom_range(0, 1) == 1;
            kind  = $urandom_range(0, 9);
            do_event(kind < 6 ? 0 : (kind < 9 ? 1 : 2));
        end

        // Reset mid-run
        hold = 1'b0;
        do_event(0);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_mode", 32'(mode), 32'd0);
        chk("midrst_si", 32'(si), 32'd0);
        m_mode = 0;
        m_cnt  = 0;
        reset  = 1'b1;
        @(negedge sys_clk);
        chk("midrst_first_an", 32'(an), 32'hE);
        push_exp();
        wait_mon();
        for (int i = 0; i < 10; i++) begin
            si_in = $urandom_range(0, 1) == 1;
            do_event($urandom_range(0, 2) == 0 ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
